npg_multi: RTL and testbench
============================

# npg_multi

Parametrised multi-channel neuromuscular pulse generator, the next generation of the single-channel ASKA stimulator. It produces charge-balanced biphasic pulses (positive phase, optional interphase gap, negative phase) at a programmable period on NCH channels, in either synchronous or round-robin interleaved mode. An amplitude envelope FSM ramps the pulse amplitude up on enable, holds it, and ramps it down on disable. It sits between the register/config block and the per-channel current-DAC drivers.

## Interface
- NCH, 4, number of stimulation channels
- FREQ_W, 12, period field width
- PD_W, 3, phase-duration and gap field width
- AMP_W, 6, amplitude width
- RAMP_W, 4, ramp-rate field width

- clk  in  1  system clock (20 kHz nominal)
- reset  in  1  synchronous, active-high reset
- enable  in  1  stimulation request; high starts/holds, low triggers ramp-down
- mode  in  1  0 = synchronous (all enabled channels together), 1 = round-robin
- ch_enable  in  NCH  channel mask
- freq  in  FREQ_W  period = freq+1 clk cycles
- phaseDuration  in  PD_W  each phase = phaseDuration+1 cycles
- gap  in  PD_W  interphase gap = gap cycles (0 = none)
- amp_max  in  AMP_W  envelope target amplitude
- up  in  RAMP_W  amp +1 after every up+1 completed pulses
- down  in  RAMP_W  amp −1 after every down+1 completed pulses
- stim_pos  out  NCH  positive-phase strobe per channel
- stim_neg  out  NCH  negative-phase strobe per channel
- amp  out  AMP_W  current amplitude, valid for the DAC whenever a strobe is high
- busy  out  1  envelope not OFF, or a pulse in progress

## Operation
- Envelope FSM: OFF, RAMP_UP, HOLD, RAMP_DOWN.
  - OFF→RAMP_UP when enable=1 and amp_max≠0. Sets amp=1, period counter pcnt=0, and the step counter to 0.
  - RAMP_UP→HOLD when amp reaches amp_max.
  - HOLD: if amp_max rises above amp, go to RAMP_UP; if amp_max falls below amp, go to RAMP_DOWN.
  - Any state with enable=0 goes to RAMP_DOWN.
  - RAMP_DOWN with enable=1 and amp≤amp_max goes to RAMP_UP (or to HOLD if equal).
  - RAMP_DOWN→OFF when amp reaches 0.
- Amp steps happen only at pulse completion (end of the negative phase), counted by the step counter against up or down. Amp saturates at amp_max going up and at 0 going down.
- Period counter: pcnt increments every cycle while not OFF and wraps to 0 after freq.
- Pulse FSM: P_IDLE, P_POS, P_GAP, P_NEG.
  - Starts only when pcnt==0 and the FSM is in P_IDLE. Otherwise that period start is skipped; pulses are never truncated.
  - freq, phaseDuration, gap and the channel selection are latched at pulse start.
- Channel selection:
  - mode 0: all channels set in ch_enable.
  - mode 1: the next set bit after the last-served channel, ascending, wrapping at NCH.
  - ch_enable=0: the pulse runs internally and counts for the ramp, but all strobes stay 0.
- Enable falling mid-pulse: the pulse completes (charge balance).
- amp is held constant for the whole pulse.

## Timing
- Reset values: stim_pos=0, stim_neg=0, amp=0, busy=0, envelope=OFF, pulse FSM=P_IDLE, round-robin pointer=NCH−1 (so the first pulse serves the lowest enabled channel).
- Reset mid-pulse: all strobes are 0 at the next edge.
- Latency: enable sampled at edge k puts the envelope in RAMP_UP. Strobes are registered; stim_pos is high from edge k+1.
- Pulse shape: stim_pos for phaseDuration+1 cycles, then gap cycles with both strobes low, then stim_neg for phaseDuration+1 cycles.
- stim_pos and stim_neg are never both high on any channel.
- The amp update is visible the cycle after stim_neg falls.
- busy drops the cycle after the last stim_neg falls with amp=0.

## Structure
- Package npg_pkg holds:
  - envelope and pulse FSM state enums;
  - the MODE_SYNC and MODE_RR constants.
- One sub-module, npg_rr_arbiter: round-robin next-channel picker over ch_enable with a pointer register.
- The rest (period counter, envelope, pulse FSM) lives in the top level.

## Test plan
- NCH=4, freq=49, phaseDuration=3, gap=0, mode=0, ch_enable=4'b1111 → every 50 cycles, stim_pos=4'hF for 4 cycles, then stim_neg=4'hF for 4 cycles.
- amp_max=4, up=1, enable held → pulse amps 1,1,2,2,3,3,4,4,…; HOLD entered after pulse 6.
- From HOLD at amp 4 with down=0, drop enable → pulses at amps 4,3,2,1, then OFF, busy=0, amp=0.
- mode=1, ch_enable=4'b1011 → channels served 0,1,3,0,1,3 on successive periods, one channel per pulse.
- freq=5, phaseDuration=3, gap=2 → 10-cycle pulse against a 6-cycle period; pulses start every 12 cycles and are never truncated.
- Assert reset mid-stim_pos → all strobes 0 and amp=0 after the next edge; after release with enable=1, restart as from OFF.

Source files
------------

// File: rtl/npg_pkg.sv
// Shared types and constants for the multi-channel biphasic pulse generator.
package npg_pkg;

  typedef enum logic [1:0] {
    ENV_OFF,
    ENV_RAMP_UP,
    ENV_HOLD,
    ENV_RAMP_DOWN
  } env_state_t;

  typedef enum logic [1:0] {
    P_IDLE,
    P_POS,
    P_GAP,
    P_NEG
  } pulse_state_t;

  localparam logic MODE_SYNC = 1'b0;
  localparam logic MODE_RR   = 1'b1;

endpackage

// File: rtl/npg_rr_arbiter.sv
// Round-robin channel picker: grants the first requesting channel after the
// last-served one, ascending and wrapping; the pointer moves only on advance.
module npg_rr_arbiter
  import npg_pkg::*;
#(
  parameter int unsigned NCH = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] req,
  input  logic           advance,
  output logic [NCH-1:0] grant_c
);

  localparam int unsigned PTR_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] nxt_c;
  logic             found_c;

  always_comb begin
    grant_c = '0;
    nxt_c   = ptr;
    found_c = 1'b0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      logic [PTR_W-1:0] idx;
      idx = PTR_W'((32'(ptr) + i) % NCH);
      if (!found_c && req[idx]) begin
        found_c      = 1'b1;
        nxt_c        = idx;
        grant_c[idx] = 1'b1;
      end
    end
  end

  // Reset to the top channel so the first grant is the lowest requester.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= PTR_W'(NCH - 1);
    end else if (advance && found_c) begin
      ptr <= nxt_c;
    end
  end

endmodule

// File: rtl/npg_multi.sv
// Multi-channel charge-balanced biphasic pulse generator with an amplitude
// envelope (ramp up / hold / ramp down) stepped at pulse completion.
module npg_multi
  import npg_pkg::*;
#(
  parameter int unsigned NCH    = 4,
  parameter int unsigned FREQ_W = 12,
  parameter int unsigned PD_W   = 3,
  parameter int unsigned AMP_W  = 6,
  parameter int unsigned RAMP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              mode,
  input  logic [NCH-1:0]    ch_enable,
  input  logic [FREQ_W-1:0] freq,
  input  logic [PD_W-1:0]   phaseDuration,
  input  logic [PD_W-1:0]   gap,
  input  logic [AMP_W-1:0]  amp_max,
  input  logic [RAMP_W-1:0] up,
  input  logic [RAMP_W-1:0] down,
  output logic [NCH-1:0]    stim_pos,
  output logic [NCH-1:0]    stim_neg,
  output logic [AMP_W-1:0]  amp,
  output logic              busy
);

  env_state_t        env;
  pulse_state_t      pst;
  logic [FREQ_W-1:0] pcnt;
  logic [FREQ_W-1:0] freq_l;
  logic [FREQ_W-1:0] pcnt_max_c;
  logic [PD_W-1:0]   cnt;
  logic [PD_W-1:0]   pd_l;
  logic [PD_W-1:0]   gap_l;
  logic [NCH-1:0]    sel_l;
  logic [NCH-1:0]    sel_c;
  logic [NCH-1:0]    grant_c;
  logic [RAMP_W-1:0] step;
  logic              p_start_c;
  logic              p_done_c;

  // A period start is taken only when no pulse is running; amp=0 never pulses.
  assign p_start_c  = (pst == P_IDLE) && (env != ENV_OFF) && (amp != '0) && (pcnt == '0);
  assign p_done_c   = (pst == P_NEG) && (cnt == pd_l);
  assign pcnt_max_c = p_start_c ? freq : freq_l;
  assign sel_c      = (mode == MODE_RR) ? grant_c : ch_enable;

  npg_rr_arbiter #(
    .NCH(NCH)
  ) u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (ch_enable),
    .advance(p_start_c && (mode == MODE_RR)),
    .grant_c(grant_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      env      <= ENV_OFF;
      pst      <= P_IDLE;
      pcnt     <= '0;
      freq_l   <= '0;
      cnt      <= '0;
      pd_l     <= '0;
      gap_l    <= '0;
      sel_l    <= '0;
      step     <= '0;
      amp      <= '0;
      busy     <= 1'b0;
      stim_pos <= '0;
      stim_neg <= '0;
    end else begin
      if (env == ENV_OFF || pcnt >= pcnt_max_c) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + FREQ_W'(1);
      end

      // Pulse sequencer: parameters frozen at start so a pulse is never reshaped.
      case (pst)
        P_IDLE: begin
          if (p_start_c) begin
            pst      <= P_POS;
            cnt      <= '0;
            freq_l   <= freq;
            pd_l     <= phaseDuration;
            gap_l    <= gap;
            sel_l    <= sel_c;
            stim_pos <= sel_c;
          end
        end
        P_POS: begin
          if (cnt == pd_l) begin
            stim_pos <= '0;
            if (gap_l == '0) begin
              pst      <= P_NEG;
              cnt      <= '0;
              stim_neg <= sel_l;
            end else begin
              pst <= P_GAP;
              cnt <= PD_W'(1);
            end
          end else begin
            cnt <= cnt + PD_W'(1);
          end
        end
        P_GAP: begin
          if (cnt == gap_l) begin
            pst      <= P_NEG;
            cnt      <= '0;
            stim_neg <= sel_l;
          end else begin
            cnt <= cnt + PD_W'(1);
          end
        end
        P_NEG: begin
          if (cnt == pd_l) begin
            pst      <= P_IDLE;
            stim_neg <= '0;
          end else begin
            cnt <= cnt + PD_W'(1);
          end
        end
        default: pst <= P_IDLE;
      endcase

      // Amplitude steps only at the end of a negative phase.
      if (p_done_c) begin
        if (env == ENV_RAMP_UP) begin
          if (step == up) begin
            step <= '0;
            if (amp < amp_max) amp <= amp + AMP_W'(1);
          end else begin
            step <= step + RAMP_W'(1);
          end
        end else if (env == ENV_RAMP_DOWN) begin
          if (step == down) begin
            step <= '0;
            if (amp != '0) amp <= amp - AMP_W'(1);
          end else begin
            step <= step + RAMP_W'(1);
          end
        end
      end

      // Envelope; step count restarts on every state change.
      case (env)
        ENV_OFF: begin
          if (enable && amp_max != '0) begin
            env  <= ENV_RAMP_UP;
            amp  <= AMP_W'(1);
            pcnt <= '0;
            step <= '0;
            busy <= 1'b1;
          end
        end
        ENV_RAMP_UP: begin
          if (!enable) begin
            env  <= ENV_RAMP_DOWN;
            step <= '0;
          end else if (amp >= amp_max) begin
            env  <= ENV_HOLD;
            step <= '0;
          end
        end
        ENV_HOLD: begin
          if (!enable || amp_max < amp) begin
            env  <= ENV_RAMP_DOWN;
            step <= '0;
          end else if (amp_max > amp) begin
            env  <= ENV_RAMP_UP;
            step <= '0;
          end
        end
        ENV_RAMP_DOWN: begin
          if (amp == '0) begin
            env  <= ENV_OFF;
            step <= '0;
            busy <= 1'b0;
          end else if (enable && amp <= amp_max) begin
            env  <= (amp == amp_max) ? ENV_HOLD : ENV_RAMP_UP;
            step <= '0;
          end
        end
        default: env <= ENV_OFF;
      endcase
    end
  end

endmodule

// File: tb/tb_npg_multi.sv
// Self-checking bench for npg_multi: a pulse monitor feeds a scoreboard that
// is compared against expected pulse records from tables and short sequences.
module tb_npg_multi;
  import npg_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        mode = 1'b0;
  logic [3:0]  ch_enable = '0;
  logic [11:0] freq = '0;
  logic [2:0]  phase_duration = '0;
  logic [2:0]  gap = '0;
  logic [5:0]  amp_max = '0;
  logic [3:0]  up = '0;
  logic [3:0]  down = '0;
  logic [3:0]  stim_pos;
  logic [3:0]  stim_neg;
  logic [5:0]  amp;
  logic        busy;

  npg_multi #(
    .NCH(4), .FREQ_W(12), .PD_W(3), .AMP_W(6), .RAMP_W(4)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .ch_enable(ch_enable),
    .freq(freq), .phaseDuration(phase_duration), .gap(gap), .amp_max(amp_max),
    .up(up), .down(down), .stim_pos(stim_pos), .stim_neg(stim_neg), .amp(amp),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] pos_mask;
    logic [3:0] neg_mask;
    int         pos_len;
    int         gap_len;
    int         neg_len;
    int         amp;
    int         spacing;
    bit         bad;
  } pulse_t;

  typedef struct {
    int         freq;
    int         pd;
    int         gap;
    logic [3:0] ch;
    int         pos_len;
    int         gap_len;
    int         neg_len;
    int         spacing;
  } vec_t;

  pulse_t exp_q[$];
  pulse_t obs_q[$];
  int errors = 0;
  int checks = 0;

  // Pulse monitor, sampling 1ns after each rising edge.
  int     cyc = 0;
  int     mph = 0;
  int     cur_start = 0;
  int     prev_start = -1;
  pulse_t cur;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (reset) begin
      mph = 0;
      prev_start = -1;
    end else begin
      if (mph != 0 && (stim_pos != 0 || stim_neg != 0)) begin
        if ((stim_pos & stim_neg) != 0 || int'(amp) != cur.amp) cur.bad = 1'b1;
      end
      case (mph)
        0: if (stim_pos != 0) begin
          cur.pos_mask = stim_pos;
          cur.neg_mask = '0;
          cur.pos_len  = 1;
          cur.gap_len  = 0;
          cur.neg_len  = 0;
          cur.amp      = int'(amp);
          cur.spacing  = 0;
          cur.bad      = (stim_neg != 0);
          cur_start    = cyc;
          mph          = 1;
        end
        1: if (stim_pos != 0) begin
          if (stim_pos != cur.pos_mask) cur.bad = 1'b1;
          cur.pos_len++;
        end else if (stim_neg != 0) begin
          cur.neg_mask = stim_neg;
          cur.neg_len  = 1;
          mph          = 3;
        end else begin
          cur.gap_len = 1;
          mph         = 2;
        end
        2: if (stim_neg != 0) begin
          cur.neg_mask = stim_neg;
          cur.neg_len  = 1;
          mph          = 3;
        end else begin
          if (stim_pos != 0) cur.bad = 1'b1;
          cur.gap_len++;
        end
        default: if (stim_neg != 0) begin
          if (stim_neg != cur.neg_mask) cur.bad = 1'b1;
          cur.neg_len++;
        end else begin
          cur.spacing = (prev_start < 0) ? 0 : cur_start - prev_start;
          prev_start  = cur_start;
          obs_q.push_back(cur);
          mph = 0;
        end
      endcase
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [3:0] pm, input logic [3:0] nm, input int pl,
                          input int gl, input int nl, input int a, input int sp);
    pulse_t p;
    p.pos_mask = pm; p.neg_mask = nm; p.pos_len = pl; p.gap_len = gl;
    p.neg_len = nl; p.amp = a; p.spacing = sp; p.bad = 1'b0;
    exp_q.push_back(p);
  endtask

  // Waits (bounded) for as many observed pulses as are expected, then scores them.
  task automatic wait_pulses(input string name, input int budget);
    int t = 0;
    int n = exp_q.size();
    while (obs_q.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (obs_q.size() < n) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got %0d pulses expected %0d", name, obs_q.size(), n);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      pulse_t e;
      pulse_t o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.bad || o.pos_mask != e.pos_mask || o.neg_mask != e.neg_mask ||
          o.pos_len != e.pos_len || o.gap_len != e.gap_len || o.neg_len != e.neg_len ||
          o.amp != e.amp || (e.spacing != 0 && o.spacing != e.spacing)) begin
        errors++;
        $display("FAIL %s pulse: got pos=%h neg=%h len=%0d/%0d/%0d amp=%0d sp=%0d bad=%0d, expected pos=%h neg=%h len=%0d/%0d/%0d amp=%0d sp=%0d",
                 name, o.pos_mask, o.neg_mask, o.pos_len, o.gap_len, o.neg_len, o.amp,
                 o.spacing, o.bad, e.pos_mask, e.neg_mask, e.pos_len, e.gap_len,
                 e.neg_len, e.amp, e.spacing);
      end
    end
    exp_q.delete();
  endtask

  // Reset, then release with enable high on the same falling edge.
  task automatic restart();
    @(negedge clk);
    reset  = 1'b1;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    enable = 1'b1;
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    vecs[0] = '{49, 3, 0, 4'hF, 4, 0, 4, 50};
    vecs[1] = '{5,  3, 2, 4'hF, 4, 2, 4, 12};
    vecs[2] = '{9,  0, 1, 4'h5, 1, 1, 1, 10};
    vecs[3] = '{20, 7, 7, 4'h2, 8, 7, 8, 42};
    vecs[4] = '{7,  3, 0, 4'hC, 4, 0, 4, 16};
    vecs[5] = '{0,  0, 0, 4'h8, 1, 0, 1, 3};

    // Reset values, enable latency, then ramp-up / hold / ramp-down.
    freq = 12'd9; phase_duration = 3'd0; gap = 3'd0; mode = MODE_SYNC;
    ch_enable = 4'hF; amp_max = 6'd4; up = 4'd1; down = 4'd0;
    repeat (2) @(negedge clk);
    check("reset_stim_pos", int'(stim_pos), 0);
    check("reset_stim_neg", int'(stim_neg), 0);
    check("reset_amp", int'(amp), 0);
    check("reset_busy", int'(busy), 0);
    reset = 1'b0; enable = 1'b1;
    @(negedge clk);
    check("lat_busy", int'(busy), 1);
    check("lat_amp", int'(amp), 1);
    check("lat_pos_early", int'(stim_pos), 0);
    @(negedge clk);
    check("lat_pos", int'(stim_pos), 15);
    push_exp(4'hF, 4'hF, 1, 0, 1, 1, 0);
    push_exp(4'hF, 4'hF, 1, 0, 1, 1, 10);
    push_exp(4'hF, 4'hF, 1, 0, 1, 2, 10);
    push_exp(4'hF, 4'hF, 1, 0, 1, 2, 10);
    push_exp(4'hF, 4'hF, 1, 0, 1, 3, 10);
    push_exp(4'hF, 4'hF, 1, 0, 1, 3, 10);
    push_exp(4'hF, 4'hF, 1, 0, 1, 4, 10);
    push_exp(4'hF, 4'hF, 1, 0, 1, 4, 10);
    wait_pulses("ramp_up", 150);
    enable = 1'b0;
    for (int a = 4; a >= 1; a--) push_exp(4'hF, 4'hF, 1, 0, 1, a, 10);
    wait_pulses("ramp_down", 100);
    check("off_amp", int'(amp), 0);
    @(negedge clk);
    check("off_busy", int'(busy), 0);
    repeat (30) @(negedge clk);
    check("off_no_pulse", obs_q.size(), 0);

    // Shape and period table.
    for (int i = 0; i < 6; i++) begin
      freq = 12'(vecs[i].freq); phase_duration = 3'(vecs[i].pd); gap = 3'(vecs[i].gap);
      ch_enable = vecs[i].ch; mode = MODE_SYNC; amp_max = 6'd1; up = 4'd0; down = 4'd0;
      restart();
      push_exp(vecs[i].ch, vecs[i].ch, vecs[i].pos_len, vecs[i].gap_len, vecs[i].neg_len, 1, 0);
      push_exp(vecs[i].ch, vecs[i].ch, vecs[i].pos_len, vecs[i].gap_len, vecs[i].neg_len, 1,
               vecs[i].spacing);
      wait_pulses($sformatf("vec%0d", i), 2 * vecs[i].spacing + 40);
    end

    // Round-robin over a sparse mask.
    freq = 12'd9; phase_duration = 3'd0; gap = 3'd0; mode = MODE_RR;
    ch_enable = 4'b1011; amp_max = 6'd1;
    restart();
    push_exp(4'h1, 4'h1, 1, 0, 1, 1, 0);
    push_exp(4'h2, 4'h2, 1, 0, 1, 1, 10);
    push_exp(4'h8, 4'h8, 1, 0, 1, 1, 10);
    push_exp(4'h1, 4'h1, 1, 0, 1, 1, 10);
    push_exp(4'h2, 4'h2, 1, 0, 1, 1, 10);
    push_exp(4'h8, 4'h8, 1, 0, 1, 1, 10);
    wait_pulses("round_robin", 100);

    // Empty mask: pulses are silent but still step the ramp.
    mode = MODE_SYNC; ch_enable = 4'h0; amp_max = 6'd2; up = 4'd0;
    restart();
    repeat (15) @(negedge clk);
    check("mask0_amp", int'(amp), 2);
    check("mask0_no_strobe", obs_q.size(), 0);

    // Reset in the middle of a positive phase, then restart.
    freq = 12'd49; phase_duration = 3'd7; gap = 3'd0; ch_enable = 4'hF;
    amp_max = 6'd3; up = 4'd0;
    restart();
    repeat (3) @(negedge clk);
    check("mid_pos_active", int'(stim_pos), 15);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_pos", int'(stim_pos), 0);
    check("mid_rst_neg", int'(stim_neg), 0);
    check("mid_rst_amp", int'(amp), 0);
    check("mid_rst_busy", int'(busy), 0);
    reset = 1'b0;
    obs_q.delete();
    @(negedge clk);
    check("mid_restart_amp", int'(amp), 1);
    check("mid_restart_early", int'(stim_pos), 0);
    @(negedge clk);
    check("mid_restart_pos", int'(stim_pos), 15);
    push_exp(4'hF, 4'hF, 8, 0, 8, 1, 0);
    push_exp(4'hF, 4'hF, 8, 0, 8, 2, 50);
    wait_pulses("mid_restart", 140);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
